// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature input conditioner.
package quad_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } chan_state_e;

    localparam int unsigned QUAD_SYNC_STAGES_DEF = 2;
    localparam int unsigned QUAD_FILT_W_DEF      = 8;
    localparam int unsigned QUAD_ERR_CNT_W       = 8;

endpackage

// File: rtl/quad_filter_chan.sv
// One encoder channel: synchroniser, stability filter FSM and counter.
// `o` takes the synchronised level after filt_len+1 consecutive differing cycles;
// `upd` pulses for one cycle on the edge where `o` changes.
module quad_filter_chan
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = QUAD_SYNC_STAGES_DEF,
    parameter int unsigned FILT_W      = QUAD_FILT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pin_raw,
    input  logic [FILT_W-1:0] filt_len,
    output logic              o,
    output logic              upd
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    chan_state_e            state_q, state_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   o_q, o_d;
    logic                   upd_q, upd_d;

    assign s   = sync_q[SYNC_STAGES-1];
    assign o   = o_q;
    assign upd = upd_q;

    // Synchroniser chain, filter state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            upd_q   <= upd_d;
        end
    end

    // Stability filter next state; >= lets a shrinking filt_len commit at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s == o_q) begin
                    cnt_d = '0;
                end else if (filt_len == '0) begin
                    o_d   = s;
                    upd_d = 1'b1;
                end else begin
                    cnt_d   = FILT_W'(1);
                    state_d = StPend;
                end
            end
            StPend: begin
                if (s == o_q) begin
                    // Glitch shorter than the window: drop it.
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q >= filt_len) begin
                    o_d     = s;
                    upd_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/quad_filter.sv
// Quadrature input conditioner: two filtered channels, change strobe and
// illegal double-step detection. Macro QUAD_FILTER_ERR_EN compiles in the
// err_step / err_cnt logic; otherwise both outputs are tied to 0.
module quad_filter
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = QUAD_SYNC_STAGES_DEF,
    parameter int unsigned FILT_W      = QUAD_FILT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_raw,
    input  logic                      b_raw,
    input  logic [FILT_W-1:0]         filt_len,
    output logic                      a,
    output logic                      b,
    output logic                      chg,
    output logic                      err_step,
    output logic [QUAD_ERR_CNT_W-1:0] err_cnt
);

    logic upd_a, upd_b;

    quad_filter_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .pin_raw  (a_raw),
        .filt_len (filt_len),
        .o        (a),
        .upd      (upd_a)
    );

    quad_filter_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .pin_raw  (b_raw),
        .filt_len (filt_len),
        .o        (b),
        .upd      (upd_b)
    );

    // upd_* are flops updated with a/b, so these strobes line up with the new levels.
    assign chg = upd_a | upd_b;

`ifdef QUAD_FILTER_ERR_EN
    logic [QUAD_ERR_CNT_W-1:0] err_cnt_q;

    assign err_step = upd_a & upd_b;
    assign err_cnt  = err_cnt_q;

    // Saturating count of double steps, one cycle behind err_step.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_step && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
`else
    assign err_step = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule
